seq_stream_tx: RTL and testbench
================================

# seq_stream_tx

Serial pattern transmitter that feeds the 101/0110 dual sequence detector. It accepts parallel words of programmable length over a valid/ready handshake and shifts them out MSB-first on a one-bit stream. It also produces `exp_y`, the cycle-exact detector output expected for that stream, so a bench or on-chip self-test can compare it directly against the detector's `y`.

## Interface
- `MAX_LEN`, 16: maximum word length in bits.
- `LEN_W`, 5: width of `in_len`; must hold `MAX_LEN`.
- `IDLE_BIT`, 1'b0: level driven on `dout` whenever no word bit is being sent.
- `CNT_W`, 16: width of `hit_count`.

Ports:
- `clk`, input, 1: clock.
- `reset`, input, 1: synchronous, active-high.
- `in_valid`, input, 1: word offered.
- `in_ready`, output, 1: word can be accepted this cycle.
- `in_data`, input, MAX_LEN: word, LSB-aligned; bit `in_len-1` is sent first.
- `in_len`, input, LEN_W: number of bits to send.
- `dout`, output, 1: serial stream, registered; connects to the detector's `din`.
- `dout_valid`, output, 1: registered; high while `dout` carries a word bit.
- `exp_y`, output, 1: combinational expected detector output for the current `dout`.
- `busy`, output, 1: high in SHIFT.
- `hit_count`, output, CNT_W: saturating count of cycles with `exp_y`=1.

## Operation
- FSM states:
  - IDLE: `dout`=`IDLE_BIT`, `dout_valid`=0.
  - SHIFT: `dout` = MSB of the shift register, `dout_valid`=1.
- Handshake:
  - `in_ready` = (state==IDLE) || (state==SHIFT && bits_left==1).
  - Accept occurs when `in_valid && in_ready`.
- On accept:
  - Effective length L = min(`in_len`, `MAX_LEN`).
  - The shift register is loaded with `in_data` left-justified so bit L-1 is emitted first.
  - bits_left = L and the FSM goes to SHIFT.
  - If L=0, the word is consumed and discarded: the FSM stays in or returns to IDLE, and `in_ready` stays high.
- SHIFT, each cycle: shift left by one and decrement bits_left. When bits_left reaches 1 with no accept, go to IDLE next cycle. An accept in that last cycle reloads and stays in SHIFT with no bubble.
- Expected-output model:
  - hist[2:0] holds the last three `dout` values, newest at bit 0. hist_cnt saturates at 3.
  - Both shift every cycle, including idle cycles, because the detector samples every clock.
  - `exp_y` = (hist_cnt≥2 && hist[1:0]==2'b10 && dout==1) || (hist_cnt≥3 && hist[2:0]==3'b011 && dout==0).
  - This gives overlapping detection of 101 and 0110.
- `hit_count` increments on each cycle with `exp_y`=1 and holds at all-ones.
- Reset values:
  - state=IDLE, `dout`=`IDLE_BIT`, `dout_valid`=0, `busy`=0, `in_ready`=1.
  - hist=0, hist_cnt=0, `hit_count`=0; therefore `exp_y`=0.
- Reset mid-word: the word is dropped with no further bits, and all state returns to the reset values in the next cycle.

## Timing
- Accept at edge k: the first bit appears on `dout` during cycle k+1, and the last bit during cycle k+L.
- A back-to-back accept at edge k+L puts the next word's first bit at cycle k+L+1 with no idle gap.
- `exp_y` is valid in the same cycle as the `dout` it refers to. It matches the detector's Mealy `y` in that cycle when both leave reset on the same edge.
- `in_ready` is combinational from registered state only. It must not depend on `in_valid`.
- `in_data`/`in_len` are sampled only at the accept edge. Changes at other times have no effect.

## Structure
- Shared package holds:
  - State enum: IDLE, SHIFT.
  - Pattern constants: PAT_A=3'b101 (length 3), PAT_B=4'b0110 (length 4).
  - The default `IDLE_BIT`.
- One sub-module, `seq_ref_model`: hist/hist_cnt registers, `exp_y` logic and `hit_count`, taking `clk`, `reset` and `dout`. It is reusable against any driver of the detector.
- The top level holds the FSM, shift register, length counter and handshake.

## Test plan
- Reset, then `in_data`=16'h0005 with `in_len`=3 accepted at edge k:
  - `dout` = 1,0,1 in cycles k+1..k+3.
  - `exp_y`=1 in cycle k+3 only.
  - `hit_count`=1.
- `in_data`=16'h0006 with `in_len`=4, after idle zeros (`IDLE_BIT`=0):
  - Stream is 0,1,1,0.
  - `exp_y`=1 on the final 0.
  - The leading idle 0 does not create an early hit.
- Overlap: `in_data`=16'h0016 with `in_len`=5, stream 1,0,1,1,0:
  - `exp_y`=1 on bits 3 and 5.
  - `hit_count`=2.
- Back-to-back: two 3-bit words 101 with `in_valid` held high:
  - 6 contiguous valid bits with no gap.
  - `in_ready` high only in IDLE and in the last-bit cycles.
  - `exp_y` hits on bits 3, 5 and 6 (stream 101101).
- `in_len`=0, then `in_len`=20:
  - The first word is consumed with `dout_valid` never asserted.
  - The second word emits exactly 16 bits.
- Reset asserted at bit 2 of an 8-bit word:
  - Next cycle: `dout`=`IDLE_BIT`, `dout_valid`=0, `hit_count`=0, `in_ready`=1.
  - No remaining bits appear.

Source files
------------

// File: rtl/seq_stream_tx_pkg.sv
// Shared definitions for the serial pattern transmitter and its detector
// reference model.
//   state_t          : transmitter FSM states
//   PAT_A / PAT_B    : detected patterns (101 and 0110), MSB is oldest bit
//   DEFAULT_IDLE_BIT : level on the stream when no word bit is sent
package seq_stream_tx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [2:0]  PAT_A     = 3'b101;
  localparam int unsigned PAT_A_LEN = 3;
  localparam logic [3:0]  PAT_B     = 4'b0110;
  localparam int unsigned PAT_B_LEN = 4;

  localparam logic DEFAULT_IDLE_BIT = 1'b0;

endpackage

// File: rtl/seq_stream_tx_ref.sv
// seq_ref_model: cycle-exact expected output of the 101/0110 overlapping
// sequence detector for whatever stream is on dout.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   dout       : stream bit presented to the detector this cycle
//   exp_y      : combinational expected detector output for dout
//   hit_count  : saturating count of cycles with exp_y=1
module seq_ref_model
  import seq_stream_tx_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dout,
  output logic             exp_y,
  output logic [CNT_W-1:0] hit_count
);

  // Number of prior bits each pattern needs before it can match.
  localparam logic [1:0] NEED_A = 2'(PAT_A_LEN - 1);
  localparam logic [1:0] NEED_B = 2'(PAT_B_LEN - 1);

  logic [2:0] hist;      // last three stream bits, newest at bit 0
  logic [1:0] hist_cnt;  // valid bits in hist, saturates at 3
  logic       hit_a;
  logic       hit_b;

  always_comb begin
    hit_a = (hist_cnt >= NEED_A) && (hist[1:0] == PAT_A[2:1]) && (dout == PAT_A[0]);
    hit_b = (hist_cnt >= NEED_B) && (hist == PAT_B[3:1]) && (dout == PAT_B[0]);
    exp_y = hit_a || hit_b;
  end

  // The detector samples every clock, so history shifts on idle cycles too.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist      <= '0;
      hist_cnt  <= '0;
      hit_count <= '0;
    end else begin
      hist     <= {hist[1:0], dout};
      hist_cnt <= (hist_cnt == 2'd3) ? hist_cnt : hist_cnt + 2'd1;
      if (exp_y && (hit_count != '1)) begin
        hit_count <= hit_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/seq_stream_tx.sv
// seq_stream_tx: accepts parallel words of programmable length over a
// valid/ready handshake and shifts them out MSB-first on a one-bit stream,
// alongside the expected output of the 101/0110 detector for that stream.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   in_valid/in_ready : word handshake (in_ready depends on state only)
//   in_data, in_len   : LSB-aligned word and its length (clamped to MAX_LEN)
//   dout, dout_valid  : registered serial stream and its qualifier
//   exp_y             : expected detector output for the current dout
//   busy              : high while shifting a word
//   hit_count         : saturating count of exp_y cycles
module seq_stream_tx
  import seq_stream_tx_pkg::*;
#(
  parameter int unsigned MAX_LEN  = 16,
  parameter int unsigned LEN_W    = 5,
  parameter logic        IDLE_BIT = DEFAULT_IDLE_BIT,
  parameter int unsigned CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MAX_LEN-1:0] in_data,
  input  logic [LEN_W-1:0]   in_len,
  output logic               dout,
  output logic               dout_valid,
  output logic               exp_y,
  output logic               busy,
  output logic [CNT_W-1:0]   hit_count
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  state_t             state;
  logic [MAX_LEN-1:0] shreg;      // MSB is the bit currently on dout
  logic [LEN_W-1:0]   bits_left;  // bits remaining including the one on dout
  logic [LEN_W-1:0]   eff_len;
  logic [MAX_LEN-1:0] load_word;
  logic               accept;
  logic               load;

  always_comb begin
    in_ready  = (state == IDLE) || ((state == SHIFT) && (bits_left == LEN_W'(1)));
    busy      = (state == SHIFT);
    eff_len   = (in_len > MAX_LEN_L) ? MAX_LEN_L : in_len;
    load_word = in_data << (MAX_LEN_L - eff_len);
    accept    = in_valid && in_ready;
    // A zero-length word is consumed without entering SHIFT.
    load      = accept && (eff_len != '0);
  end

  // dout/dout_valid are loaded with the value the shift register will
  // present next cycle, keeping them registered yet aligned with shreg[MSB].
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bits_left  <= '0;
      dout       <= IDLE_BIT;
      dout_valid <= 1'b0;
    end else if (load) begin
      state      <= SHIFT;
      shreg      <= load_word;
      bits_left  <= eff_len;
      dout       <= load_word[MAX_LEN-1];
      dout_valid <= 1'b1;
    end else if ((state == SHIFT) && (bits_left != LEN_W'(1))) begin
      shreg      <= shreg << 1;
      bits_left  <= bits_left - LEN_W'(1);
      dout       <= shreg[MAX_LEN-2];
      dout_valid <= 1'b1;
    end else begin
      state      <= IDLE;
      bits_left  <= '0;
      dout       <= IDLE_BIT;
      dout_valid <= 1'b0;
    end
  end

  seq_ref_model #(
    .CNT_W(CNT_W)
  ) u_ref (
    .clk      (clk),
    .reset    (reset),
    .dout     (dout),
    .exp_y    (exp_y),
    .hit_count(hit_count)
  );

endmodule

// File: tb/tb_seq_stream_tx.sv
// Scoreboard bench for seq_stream_tx: accepted words push their expected
// bit sequence into a queue; a monitor on the falling edge pops one bit per
// cycle and checks the stream, handshake and expected detector output.
module tb_seq_stream_tx;

  localparam logic IDLE_BIT = 1'b0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [4:0]  in_len = '0;
  logic        dout;
  logic        dout_valid;
  logic        exp_y;
  logic        busy;
  logic [15:0] hit_count;

  seq_stream_tx #(
    .MAX_LEN (16),
    .LEN_W   (5),
    .IDLE_BIT(IDLE_BIT),
    .CNT_W   (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_len    (in_len),
    .dout      (dout),
    .dout_valid(dout_valid),
    .exp_y     (exp_y),
    .busy      (busy),
    .hit_count (hit_count)
  );

  always #5 clk = ~clk;

  bit          exp_q[$];   // bits still to be sent, in order
  bit          stream[$];  // recent expected stream since reset, newest last
  int unsigned hits;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Detector rule stated directly on the bit stream: 101 or 0110 ending now.
  function automatic bit ref_hit();
    int  n = stream.size();
    bit  a = 1'b0;
    bit  b = 1'b0;
    if (n >= 3) a = (stream[n-3] == 1'b1) && (stream[n-2] == 1'b0) && (stream[n-1] == 1'b1);
    if (n >= 4) b = (stream[n-4] == 1'b0) && (stream[n-3] == 1'b1) &&
                    (stream[n-2] == 1'b1) && (stream[n-1] == 1'b0);
    return a || b;
  endfunction

  // Monitor
  initial begin
    bit ev, eb, ey;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        stream.delete();
        stream.push_back(IDLE_BIT);
        hits = 0;
        check("rst_dout", 32'(dout), 32'(IDLE_BIT));
        check("rst_dout_valid", 32'(dout_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_hit_count", 32'(hit_count), 32'd0);
        check("rst_exp_y", 32'(exp_y), 32'd0);
      end else begin
        if (exp_q.size() > 0) begin
          ev = 1'b1;
          eb = exp_q.pop_front();
        end else begin
          ev = 1'b0;
          eb = IDLE_BIT;
        end
        check("dout_valid", 32'(dout_valid), 32'(ev));
        check("dout", 32'(dout), 32'(eb));
        check("busy", 32'(busy), 32'(ev));
        check("in_ready", 32'(in_ready), 32'(exp_q.size() == 0));
        check("hit_count", 32'(hit_count), hits);
        stream.push_back(eb);
        ey = ref_hit();
        check("exp_y", 32'(exp_y), 32'(ey));
        if (ey && hits != 32'hFFFF) hits++;
        if (stream.size() > 4) void'(stream.pop_front());
      end
    end
  end

  // One stimulus cycle. The word is taken when the model has nothing left to
  // send beyond the bit currently on the stream.
  task automatic drive(input logic v, input logic [15:0] d, input logic [4:0] l, output bit acc);
    int unsigned n;
    @(negedge clk);
    #1;
    reset    = 1'b0;
    in_valid = v;
    in_data  = d;
    in_len   = l;
    acc = v && (exp_q.size() == 0);
    if (acc) begin
      n = (l > 5'd16) ? 16 : int'(l);
      for (int i = int'(n) - 1; i >= 0; i--) exp_q.push_back(d[i]);
    end
  endtask

  task automatic send_word(input logic [15:0] d, input logic [4:0] l);
    bit acc = 1'b0;
    int tries = 0;
    while (!acc && tries < 40) begin
      drive(1'b1, d, l, acc);
      tries++;
    end
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: word %0h len %0d not taken", d, l);
    end
  endtask

  // Idle cycles scramble in_data/in_len; they must have no effect.
  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) drive(1'b0, 16'($urandom), 5'($urandom), acc);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      reset    = 1'b1;
      in_valid = 1'b0;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int r;
    logic [4:0] l;
    do_reset(3);
    idle(3);
    send_word(16'h0005, 5'd3);   // 101
    idle(4);
    send_word(16'h0006, 5'd4);   // 0110 after idle zeros
    idle(3);
    send_word(16'h0016, 5'd5);   // 10110, overlapping hits
    idle(3);
    send_word(16'h0005, 5'd3);   // back-to-back 101101
    send_word(16'h0005, 5'd3);
    idle(3);
    send_word(16'hFFFF, 5'd0);   // discarded
    send_word(16'hB3C5, 5'd20);  // clamped to 16 bits
    idle(3);
    send_word(16'h00A7, 5'd8);   // reset while bit 2 is on the stream
    idle(1);
    do_reset(1);
    idle(4);
    for (int k = 0; k < 1500; k++) begin
      r = $urandom_range(0, 99);
      if (r < 1) begin
        do_reset(1 + $urandom_range(0, 2));
      end else begin
        l = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(0, 16));
        drive(r < 65, 16'($urandom), l, acc);
      end
    end
    idle(25);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
